// File: rtl/ifu_prefetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch stage: bus widths, opcodes,
// the NOP bubble, fetch FSM states and the prefetch FIFO entry layout.
package ifu_prefetch_pkg;

  localparam int INST_BUS_W      = 32;
  localparam int INST_ADDR_BUS_W = 32;

  localparam logic [INST_BUS_W-1:0]      INST_NOP  = 32'h0000_0013;
  localparam logic [INST_ADDR_BUS_W-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [6:0] INST_JAL    = 7'b1101111;
  localparam logic [6:0] INST_TYPE_B = 7'b1100011;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INST_BUS_W-1:0]      inst;
    logic [INST_ADDR_BUS_W-1:0] addr;
    logic                       prdt;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; the pointers wrap naturally because DEPTH is a power of two.
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch stage feeding IF/ID: issues word fetches, buffers responses with a static
// branch prediction, and honours execute-stage redirects by discarding stale responses.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter logic [INST_ADDR_BUS_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                         FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       jump_flag_i,
  input  logic [INST_ADDR_BUS_W-1:0] jump_addr_i,
  input  logic                       stall_flag_i,
  output logic                       ibus_req_o,
  output logic [INST_ADDR_BUS_W-1:0] ibus_addr_o,
  input  logic                       ibus_gnt_i,
  input  logic                       ibus_rvalid_i,
  input  logic [INST_BUS_W-1:0]      ibus_rdata_i,
  output logic [INST_BUS_W-1:0]      inst_o,
  output logic [INST_ADDR_BUS_W-1:0] inst_addr_o,
  output logic                       prdt_taken_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int EW = $bits(fetch_entry_t);

  fetch_state_t                 state_q, state_d;
  logic [INST_ADDR_BUS_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]                drop_q, drop_d;

  logic [CW-1:0]                fifo_count, aq_count, live_count, out_next;
  logic                         fifo_full, fifo_empty, aq_full, aq_empty;
  logic [OW-1:0]                occupancy;
  logic                         issue, resp, resp_drop, resp_keep, fifo_pop;
  logic [INST_ADDR_BUS_W-1:0]   rsp_addr;
  logic [6:0]                   opcode;
  logic                         is_jal, is_bneg, pred_taken, redirect;
  logic [INST_ADDR_BUS_W-1:0]   imm_j, imm_b, pred_target;
  fetch_entry_t                 push_entry, head_entry;

  // Only responses not yet marked for discard will land in the FIFO, so they alone count against capacity.
  assign live_count = aq_count - drop_q;
  assign occupancy  = OW'(fifo_count) + OW'(live_count);

  assign ibus_req_o  = (state_q != S_BOOT) && (occupancy < OW'(FIFO_DEPTH)) && !aq_full && !fifo_full;
  assign ibus_addr_o = fetch_pc_q;

  assign issue     = ibus_req_o && ibus_gnt_i;
  // A response with nothing outstanding is a leftover from before reset and is ignored.
  assign resp      = ibus_rvalid_i && !aq_empty;
  assign resp_drop = resp && (drop_q != '0);
  assign resp_keep = resp && (drop_q == '0) && !jump_flag_i;

  assign opcode      = ibus_rdata_i[6:0];
  assign imm_j       = {{12{ibus_rdata_i[31]}}, ibus_rdata_i[19:12], ibus_rdata_i[20],
                        ibus_rdata_i[30:21], 1'b0};
  assign imm_b       = {{20{ibus_rdata_i[31]}}, ibus_rdata_i[7], ibus_rdata_i[30:25],
                        ibus_rdata_i[11:8], 1'b0};
  assign is_jal      = (opcode == INST_JAL);
  assign is_bneg     = (opcode == INST_TYPE_B) && ibus_rdata_i[31];
  assign pred_taken  = resp_keep && (is_jal || is_bneg);
  assign pred_target = rsp_addr + (is_jal ? imm_j : imm_b);
  assign redirect    = jump_flag_i || pred_taken;

  // Requests still in flight once this cycle's grant and response are accounted for.
  assign out_next = aq_count + CW'(issue) - CW'(resp);

  assign push_entry = '{inst: ibus_rdata_i, addr: rsp_addr, prdt: pred_taken};
  assign fifo_pop   = !stall_flag_i && !fifo_empty && !jump_flag_i;

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (jump_flag_i),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Addresses of outstanding requests in issue order; dropped responses still retire their entry.
  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INST_ADDR_BUS_W)
  ) u_addr_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (issue),
    .push_data (fetch_pc_q),
    .pop       (resp),
    .pop_data  (rsp_addr),
    .full      (aq_full),
    .empty     (aq_empty),
    .count     (aq_count)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q - CW'(resp_drop);

    if (redirect) drop_d = out_next;

    if (jump_flag_i)     fetch_pc_d = jump_addr_i;
    else if (pred_taken) fetch_pc_d = pred_target;
    else if (issue)      fetch_pc_d = fetch_pc_q + 32'd4;

    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (redirect && (out_next != '0)) state_d = S_FLUSH;
      S_FLUSH: if (drop_d == '0) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    inst_o       = INST_NOP;
    inst_addr_o  = ZERO_WORD;
    prdt_taken_o = 1'b0;
    if (!jump_flag_i && !fifo_empty) begin
      inst_o       = head_entry.inst;
      inst_addr_o  = head_entry.addr;
      prdt_taken_o = head_entry.prdt;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: an in-order bus responder with holdable latency,
// plus logs of issued and consumed addresses checked against hand-written sequences.
module tb_ifu_prefetch;
  import ifu_prefetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        stall_flag_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        prdt_taken_o;

  int n_checks = 0;
  int n_fail   = 0;

  bit          br_en, jal_en, resp_en;
  logic [31:0] pend_q[$];
  logic [31:0] iss_q[$];
  logic [31:0] pop_q[$];

  ifu_prefetch dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .stall_flag_i  (stall_flag_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .prdt_taken_o  (prdt_taken_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Program image: addi x1,x0,<addr> everywhere except the branch/jump words under test.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (br_en  && a == 32'h10) return 32'hFE00_0EE3;
    if (jal_en && a == 32'h20) return 32'h0100_006F;
    if (jal_en && a == 32'h30) return 32'h0000_0463;
    return {a[11:0], 5'd0, 3'b000, 5'd1, 7'h13};
  endfunction

  function automatic logic exp_prdt(input logic [31:0] a);
    return (br_en && a == 32'h10) || (jal_en && a == 32'h20);
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    return (i < pop_q.size()) ? pop_q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] iss_at(input int i);
    return (i < iss_q.size()) ? iss_q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic int outstanding();
    return pend_q.size() + (ibus_rvalid_i ? 1 : 0);
  endfunction

  // One clock: log grant and consumption for the coming edge, then drive the next response.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    g = ibus_req_o && ibus_gnt_i;
    a = ibus_addr_o;
    if (g) begin
      iss_q.push_back(a);
      pend_q.push_back(a);
    end
    if (!rst && !stall_flag_i && !jump_flag_i && inst_o != INST_NOP) begin
      pop_q.push_back(inst_addr_o);
      check("pop_inst", inst_o, mem_word(inst_addr_o));
      check("pop_prdt", 32'(prdt_taken_o), 32'(exp_prdt(inst_addr_o)));
    end
    @(negedge clk);
    if (resp_en && pend_q.size() > 0) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = mem_word(pend_q.pop_front());
    end else begin
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    stall_flag_i  = 1'b0;
    jump_flag_i   = 1'b0;
    jump_addr_i   = 32'h0;
    ibus_gnt_i    = 1'b1;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = 32'h0;
    resp_en       = 1'b1;
    pend_q.delete();
    @(negedge clk);
    check("rst_inst", inst_o, INST_NOP);
    check("rst_addr", inst_addr_o, 32'h0);
    check("rst_prdt", 32'(prdt_taken_o), 32'h0);
    check("rst_req", 32'(ibus_req_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    iss_q.delete();
    pop_q.delete();
  endtask

  initial begin
    int          n0;
    int          n_iss;
    int          n_pop;
    logic [31:0] hold_addr;
    bit          found;

    rst = 1'b1;
    br_en = 1'b0;
    jal_en = 1'b0;

    // Straight-line fetch, 1-cycle bus latency.
    do_reset();
    tick();
    check("boot_req", 32'(ibus_req_o), 32'h1);
    check("boot_addr", ibus_addr_o, 32'h0);
    tick();
    check("lat_empty", inst_o, INST_NOP);
    tick();
    check("lat_addr", inst_addr_o, 32'h0);
    check("lat_inst", inst_o, 32'h0000_0093);
    repeat (9) tick();
    for (int i = 0; i < 8; i++) begin
      check("seq_iss", iss_at(i), 32'(4 * i));
      check("seq_pop", pop_at(i), 32'(4 * i));
    end

    // Stall: issue bounded by FIFO depth, head held, in-order drain afterwards.
    stall_flag_i = 1'b1;
    hold_addr = inst_addr_o;
    n0 = iss_q.size();
    repeat (10) tick();
    check("stall_req_bound", 32'((iss_q.size() - n0) <= 4), 32'h1);
    check("stall_req_low", 32'(ibus_req_o), 32'h0);
    check("stall_hold", inst_addr_o, hold_addr);
    stall_flag_i = 1'b0;
    repeat (12) tick();
    for (int i = 0; i < 16; i++) check("drain_pop", pop_at(i), 32'(4 * i));

    // Backward beq at 0x10 predicted taken back to 0x0C.
    br_en = 1'b1;
    do_reset();
    repeat (20) tick();
    check("br_iss5", iss_at(5), 32'h14);
    check("br_iss6", iss_at(6), 32'h0C);
    check("br_iss7", iss_at(7), 32'h10);
    check("br_pop4", pop_at(4), 32'h10);
    check("br_pop5", pop_at(5), 32'h0C);
    check("br_pop6", pop_at(6), 32'h10);
    found = 1'b0;
    foreach (pop_q[i]) if (pop_q[i] == 32'h14) found = 1'b1;
    check("br_drop14", 32'(found), 32'h0);

    // JAL at 0x20 to 0x30; forward beq at 0x30 falls through.
    br_en = 1'b0;
    jal_en = 1'b1;
    do_reset();
    repeat (22) tick();
    check("jal_iss9", iss_at(9), 32'h24);
    check("jal_iss10", iss_at(10), 32'h30);
    check("jal_pop8", pop_at(8), 32'h20);
    check("jal_pop9", pop_at(9), 32'h30);
    check("jal_pop10", pop_at(10), 32'h34);
    check("jal_pop11", pop_at(11), 32'h38);

    // Execute redirect to 0x100 with three requests outstanding.
    jal_en = 1'b0;
    do_reset();
    repeat (6) tick();
    resp_en = 1'b0;
    for (int i = 0; i < 20 && outstanding() != 3; i++) tick();
    check("jmp_out3", 32'(outstanding()), 32'd3);
    ibus_gnt_i  = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h100;
    #1;
    check("jmp_inst", inst_o, INST_NOP);
    check("jmp_addr", inst_addr_o, 32'h0);
    check("jmp_prdt", 32'(prdt_taken_o), 32'h0);
    n_iss = iss_q.size();
    n_pop = pop_q.size();
    tick();
    jump_flag_i = 1'b0;
    ibus_gnt_i  = 1'b1;
    resp_en     = 1'b1;
    check("jmp_flushed", inst_o, INST_NOP);
    repeat (12) tick();
    check("jmp_iss0", iss_at(n_iss), 32'h100);
    check("jmp_pop0", pop_at(n_pop), 32'h100);
    check("jmp_pop1", pop_at(n_pop + 1), 32'h104);
    check("jmp_pop2", pop_at(n_pop + 2), 32'h108);

    // Reset asserted mid-burst, then a stale response while nothing is outstanding.
    do_reset();
    repeat (6) tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_inst", inst_o, INST_NOP);
    check("mid_rst_addr", inst_addr_o, 32'h0);
    check("mid_rst_prdt", 32'(prdt_taken_o), 32'h0);
    check("mid_rst_req", 32'(ibus_req_o), 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    iss_q.delete();
    pop_q.delete();
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = 32'h0100_006F;
    repeat (10) tick();
    check("rst_iss0", iss_at(0), 32'h0);
    check("rst_pop0", pop_at(0), 32'h0);
    check("rst_pop1", pop_at(1), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
